// File: rtl/bd4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bd4_pkg
//  Description : Shared types and constants for the 4-phase bundled-data
//                transmitter and receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package bd4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } bd4_state_t;

    localparam int BD4_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : Multi-flop synchronizer for one asynchronous level signal.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bd4_sync_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bd4_sync_tx
//  Description : Clocked sender for a 4-phase bundled-data channel; data setup
//                before the request is counted in whole clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module bd4_sync_tx
    import bd4_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     bd_data,
    output logic                 bd_req,
    input  logic                 bd_ack,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [BD4_CNT_W-1:0] tx_count
);

    localparam int                   c_SETUP_W    = 4;
    localparam logic [c_SETUP_W-1:0] c_SETUP_LOAD = c_SETUP_W'(SETUP_CYCLES - 1);

    bd4_state_t           r_state, w_state_nxt;
    logic [c_SETUP_W-1:0] r_setup_cnt, w_setup_cnt_nxt;
    logic [WIDTH-1:0]     r_bd_data, w_bd_data_nxt;
    logic                 r_bd_req, w_bd_req_nxt;
    logic [BD4_CNT_W-1:0] r_tx_count, w_tx_count_nxt;
    logic                 w_ack_s;

    // The acknowledge only ever reaches the FSM through this synchronizer.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bd_ack),
        .q   (w_ack_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_setup_cnt <= '0;
            r_bd_data   <= '0;
            r_bd_req    <= 1'b0;
            r_tx_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_setup_cnt <= w_setup_cnt_nxt;
            r_bd_data   <= w_bd_data_nxt;
            r_bd_req    <= w_bd_req_nxt;
            r_tx_count  <= w_tx_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_setup_cnt_nxt = r_setup_cnt;
        w_bd_data_nxt   = r_bd_data;
        w_bd_req_nxt    = r_bd_req;
        w_tx_count_nxt  = r_tx_count;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_bd_data_nxt   = in_data;
                    w_setup_cnt_nxt = c_SETUP_LOAD;
                    w_state_nxt     = SETUP;
                end
            end
            SETUP: begin
                // A stale high ack here is ignored; only REQ_HI looks at it.
                if (r_setup_cnt == '0) begin
                    w_bd_req_nxt = 1'b1;
                    w_state_nxt  = REQ_HI;
                end else begin
                    w_setup_cnt_nxt = r_setup_cnt - 1'b1;
                end
            end
            REQ_HI: begin
                if (w_ack_s) begin
                    w_bd_req_nxt = 1'b0;
                    w_state_nxt  = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!w_ack_s) begin
                    w_tx_count_nxt = r_tx_count + 1'b1;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int                c_TO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
            localparam logic [c_TO_W-1:0] c_TO_LIM = c_TO_W'(TIMEOUT);

            logic [c_TO_W-1:0] r_to_cnt;
            logic              r_err;
            logic              w_waiting;

            // Counting restarts whenever the state is about to change.
            assign w_waiting = ((r_state == REQ_HI) || (r_state == REQ_LO)) &&
                               (w_state_nxt == r_state);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_to_cnt <= '0;
                    r_err    <= 1'b0;
                end else begin
                    if (!w_waiting) begin
                        r_to_cnt <= '0;
                    end else if (r_to_cnt != c_TO_LIM) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                    if (w_waiting && (r_to_cnt == c_TO_LIM - 1'b1)) begin
                        r_err <= 1'b1;
                    end
                end
            end

            assign timeout_err = r_err;
        end else begin : g_no_timeout
            assign timeout_err = 1'b0;
        end
    endgenerate

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign bd_data  = r_bd_data;
    assign bd_req   = r_bd_req;
    assign tx_count = r_tx_count;

endmodule
`default_nettype wire
